// File: rtl/llc_pipe_fifo_pkg.sv
// Shared types and per-boundary sizing for the LLC pipeline queues.
// Packet layouts travel between decode, local mem, lookup and process.
package llc_pipe_fifo_pkg;

    localparam int LLC_FIFO_MEM_DEPTH    = 4;
    localparam int LLC_FIFO_LOOKUP_DEPTH = 3;
    localparam int LLC_FIFO_PROC_DEPTH   = 2;
    localparam int LLC_FIFO_AFULL_MARGIN = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [3:0]  id;
    } fifo_mem_packet;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [3:0]  id;
        logic        mem_hit;
    } fifo_mem_lookup_packet;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic        hit;
        logic [3:0]  way;
    } fifo_look_proc_packet;

    // Threshold that leaves AFULL_MARGIN free slots, never below one entry.
    function automatic int afull_for(input int depth);
        return (depth > LLC_FIFO_AFULL_MARGIN) ?
               depth - LLC_FIFO_AFULL_MARGIN : 1;
    endfunction

endpackage

// File: rtl/llc_pipe_fifo_ctrl.sv
// Queue control for llc_pipe_fifo: pointers, occupancy and sticky flags.
// Optional fall-through selected by LLC_PIPE_FIFO_BYPASS_EN.
module llc_pipe_fifo_ctrl
    import llc_pipe_fifo_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3,
    parameter int PW           = 2,
    parameter int UW           = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic          wr_en,
    output logic          bypass,
    output logic [UW-1:0] usage,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);
    localparam logic [UW-1:0] AFULL_U = UW'(AFULL_THRESH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    logic          push_ok;
    logic          pop_ok;
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] rd_nxt;
    logic [UW-1:0] usage_nxt;
    logic          ovf_nxt;
    logic          unf_nxt;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full  = (usage == DEPTH_U);
    assign empty = (usage == '0);
    assign afull = (usage >= AFULL_U);

`ifdef LLC_PIPE_FIFO_BYPASS_EN
    assign bypass = empty & push & pop & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign push_ok = push & ~full & ~bypass;
    assign pop_ok  = pop & ~empty;
    assign wr_en   = push_ok & ~flush;

    // Next pointers, occupancy and flags; flush wins over push and pop.
    always_comb begin
        wr_nxt    = wr_ptr;
        rd_nxt    = rd_ptr;
        usage_nxt = usage;
        ovf_nxt   = overflow;
        unf_nxt   = underflow;
        if (flush) begin
            wr_nxt    = '0;
            rd_nxt    = '0;
            usage_nxt = '0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
        end else begin
            if (push_ok) wr_nxt = wrap(wr_ptr);
            if (pop_ok)  rd_nxt = wrap(rd_ptr);
            unique case (1'b1)
                push_ok & ~pop_ok: usage_nxt = usage + UW'(1);
                pop_ok & ~push_ok: usage_nxt = usage - UW'(1);
                default:           usage_nxt = usage;
            endcase
            if (push & full)            ovf_nxt = 1'b1;
            if (pop & empty & ~bypass)  unf_nxt = 1'b1;
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usage     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            usage     <= usage_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
        end
    end

endmodule

// File: rtl/llc_pipe_fifo.sv
// Parametrised inter-stage queue for the LLC pipeline.
// Define LLC_PIPE_FIFO_BYPASS_EN for empty-queue fall-through.
module llc_pipe_fifo
    import llc_pipe_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  DEPTH        = 4,
    parameter int  AFULL_THRESH = DEPTH - 1,
    parameter type dtype        = logic [DATA_WIDTH-1:0],
    localparam int PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int UW           = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  dtype          data_in,
    input  logic          pop,
    output dtype          data_out,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic [UW-1:0] usage,
    output logic          overflow,
    output logic          underflow
);

    if (DEPTH < 1 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_cfg
        $fatal(1, "llc_pipe_fifo: bad DEPTH/AFULL_THRESH");
    end

    dtype          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          bypass;

    llc_pipe_fifo_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH),
        .PW           (PW),
        .UW           (UW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .wr_en     (wr_en),
        .bypass    (bypass),
        .usage     (usage),
        .full      (full),
        .empty     (empty),
        .afull     (afull),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Payload storage; contents survive reset and are masked by empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    // Head selection: fall-through, stored head, or zero when empty.
    always_comb begin
        data_out = '0;
        if (bypass)      data_out = data_in;
        else if (!empty) data_out = mem[rd_ptr];
    end

endmodule

// File: tb/tb_llc_pipe_fifo.sv
// Directed bench for llc_pipe_fifo at depths 4, 3 and 1.
// Honours LLC_PIPE_FIFO_BYPASS_EN for the fall-through cases.
module tb_llc_pipe_fifo;
    import llc_pipe_fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [1:0] sel;

    logic [7:0] do4, do3, do1;
    logic       fu4, fu3, fu1, em4, em3, em1, af4, af3, af1;
    logic       ov4, ov3, ov1, un4, un3, un1;
    logic [2:0] us4;
    logic [1:0] us3;
    logic [0:0] us1;

    logic [31:0] o_do, o_us, o_fu, o_em, o_af, o_ov, o_un;

    int n_chk;
    int n_fail;

    llc_pipe_fifo #(.DATA_WIDTH(8), .DEPTH(LLC_FIFO_MEM_DEPTH)) u4 (
        .clk(clk), .rst(rst), .flush(flush),
        .push(push && sel == 2'd0), .data_in(din), .pop(pop && sel == 2'd0),
        .data_out(do4), .full(fu4), .empty(em4), .afull(af4),
        .usage(us4), .overflow(ov4), .underflow(un4)
    );

    llc_pipe_fifo #(.DATA_WIDTH(8), .DEPTH(LLC_FIFO_LOOKUP_DEPTH)) u3 (
        .clk(clk), .rst(rst), .flush(flush),
        .push(push && sel == 2'd1), .data_in(din), .pop(pop && sel == 2'd1),
        .data_out(do3), .full(fu3), .empty(em3), .afull(af3),
        .usage(us3), .overflow(ov3), .underflow(un3)
    );

    llc_pipe_fifo #(.DATA_WIDTH(8), .DEPTH(1), .AFULL_THRESH(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .push(push && sel == 2'd2), .data_in(din), .pop(pop && sel == 2'd2),
        .data_out(do1), .full(fu1), .empty(em1), .afull(af1),
        .usage(us1), .overflow(ov1), .underflow(un1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        o_do = 32'(do4); o_us = 32'(us4); o_fu = 32'(fu4); o_em = 32'(em4);
        o_af = 32'(af4); o_ov = 32'(ov4); o_un = 32'(un4);
        case (sel)
            2'd1: begin
                o_do = 32'(do3); o_us = 32'(us3); o_fu = 32'(fu3); o_em = 32'(em3);
                o_af = 32'(af3); o_ov = 32'(ov3); o_un = 32'(un3);
            end
            2'd2: begin
                o_do = 32'(do1); o_us = 32'(us1); o_fu = 32'(fu1); o_em = 32'(em1);
                o_af = 32'(af1); o_ov = 32'(ov1); o_un = 32'(un1);
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic p, input logic q, input logic [7:0] d);
        push = p;
        pop  = q;
        din  = d;
    endtask

    int         cnt;
    int         pre;
    logic [7:0] mdat;
    logic       movf, munf, bp, p, q;
    logic [7:0] d;

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; flush = 1'b0; sel = 2'd0;
        drv(0, 0, 8'h00);
        #1 rst = 1'b0;
        #1;
        chk("rst_usage", o_us, 0);
        chk("rst_empty", o_em, 1);
        chk("rst_full", o_fu, 0);
        chk("rst_afull", o_af, 0);
        chk("rst_ovf", o_ov, 0);
        chk("rst_unf", o_un, 0);
        chk("rst_dout", o_do, 0);
        #11 rst = 1'b1;

        // depth 4: three pushes then three pops
        drv(1, 0, 8'hA1); tick;
        chk("t1_do_a", o_do, 'hA1); chk("t1_us_a", o_us, 1); chk("t1_af_a", o_af, 0);
        chk("t1_em_a", o_em, 0);
        drv(1, 0, 8'hA2); tick;
        chk("t1_do_b", o_do, 'hA1); chk("t1_us_b", o_us, 2); chk("t1_af_b", o_af, 0);
        drv(1, 0, 8'hA3); tick;
        chk("t1_us_c", o_us, 3); chk("t1_af_c", o_af, 1); chk("t1_fu_c", o_fu, 0);
        drv(0, 1, 8'h00); tick;
        chk("t1_do_d", o_do, 'hA2); chk("t1_us_d", o_us, 2); chk("t1_af_d", o_af, 0);
        tick;
        chk("t1_do_e", o_do, 'hA3); chk("t1_us_e", o_us, 1);
        tick;
        chk("t1_us_f", o_us, 0); chk("t1_em_f", o_em, 1); chk("t1_unf_f", o_un, 0);
        drv(0, 0, 8'h00);

        // depth 3: wrap with interleaved pops, then overflow
        sel = 2'd1;
        drv(1, 0, 8'h11); tick;
        chk("t2_do_a", o_do, 'h11); chk("t2_us_a", o_us, 1);
        drv(1, 0, 8'h12); tick;
        chk("t2_do_b", o_do, 'h11); chk("t2_us_b", o_us, 2); chk("t2_af_b", o_af, 1);
        drv(1, 1, 8'h13); tick;
        chk("t2_do_c", o_do, 'h12); chk("t2_us_c", o_us, 2);
        drv(1, 1, 8'h14); tick;
        chk("t2_do_d", o_do, 'h13); chk("t2_us_d", o_us, 2);
        drv(1, 0, 8'h15); tick;
        chk("t2_do_e", o_do, 'h13); chk("t2_us_e", o_us, 3); chk("t2_fu_e", o_fu, 1);
        drv(1, 0, 8'h16); tick;
        chk("t2_ovf_f", o_ov, 1); chk("t2_us_f", o_us, 3); chk("t2_do_f", o_do, 'h13);
        drv(0, 0, 8'h00); tick;
        chk("t2_ovf_sticky", o_ov, 1);

        // full with push+pop, then half-full push+pop
        drv(1, 1, 8'h17); tick;
        chk("t3_us_a", o_us, 2); chk("t3_do_a", o_do, 'h14);
        chk("t3_fu_a", o_fu, 0); chk("t3_ovf_a", o_ov, 1);
        drv(0, 1, 8'h00); tick;
        chk("t3_do_b", o_do, 'h15); chk("t3_us_b", o_us, 1);
        tick;
        chk("t3_em_c", o_em, 1); chk("t3_us_c", o_us, 0);
        drv(1, 0, 8'h21); tick;
        chk("t3_do_d", o_do, 'h21); chk("t3_us_d", o_us, 1);
        drv(1, 1, 8'h22); tick;
        chk("t3_do_e", o_do, 'h22); chk("t3_us_e", o_us, 1);

        // underflow and fall-through
        drv(0, 1, 8'h00); tick;
        chk("t4_em_a", o_em, 1); chk("t4_unf_a", o_un, 0);
        drv(0, 0, 8'h00); flush = 1'b1; tick; flush = 1'b0;
        chk("t4_ovf_clr", o_ov, 0); chk("t4_unf_clr", o_un, 0);
        drv(0, 1, 8'h00); tick;
        chk("t4_unf_set", o_un, 1); chk("t4_em_b", o_em, 1);
        drv(0, 0, 8'h00); flush = 1'b1; tick; flush = 1'b0;
        chk("t4_unf_clr2", o_un, 0);
        drv(1, 1, 8'h55); #1;
`ifdef LLC_PIPE_FIFO_BYPASS_EN
        chk("t4_byp_do", o_do, 'h55);
        chk("t4_byp_em", o_em, 1);
`endif
        tick;
`ifdef LLC_PIPE_FIFO_BYPASS_EN
        chk("t4_byp_us", o_us, 0);
        chk("t4_byp_unf", o_un, 0);
        chk("t4_byp_em2", o_em, 1);
`else
        chk("t4_nb_us", o_us, 1);
        chk("t4_nb_do", o_do, 'h55);
        chk("t4_nb_unf", o_un, 1);
`endif
        drv(0, 0, 8'h00);

        // flush beats push and pop
        sel = 2'd0;
        drv(0, 1, 8'h00); tick;
        chk("t5_unf_a", o_un, 1);
        drv(1, 0, 8'h31); tick;
        drv(1, 0, 8'h32); tick;
        drv(1, 0, 8'h33); tick;
        chk("t5_us_a", o_us, 3);
        drv(1, 1, 8'h34); flush = 1'b1; tick; flush = 1'b0;
        drv(0, 0, 8'h00);
        chk("t5_us_b", o_us, 0); chk("t5_em_b", o_em, 1); chk("t5_unf_b", o_un, 0);
        chk("t5_ovf_b", o_ov, 0); chk("t5_af_b", o_af, 0); chk("t5_do_b", o_do, 0);
        drv(1, 0, 8'h77); tick;
        chk("t5_do_c", o_do, 'h77); chk("t5_us_c", o_us, 1);

        // asynchronous reset mid-stream
        drv(1, 0, 8'h88);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t6_us", o_us, 0); chk("t6_em", o_em, 1); chk("t6_do", o_do, 0);
        chk("t6_fu", o_fu, 0); chk("t6_af", o_af, 0);
        drv(0, 0, 8'h00);
        #2 rst = 1'b1;
        tick;
        chk("t6_us_after", o_us, 0);

        // depth 1 random traffic against a count model
        sel = 2'd2;
        cnt = 0; mdat = 8'h00; movf = 1'b0; munf = 1'b0;
        for (int i = 0; i < 100; i++) begin
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            drv(p, q, d);
`ifdef LLC_PIPE_FIFO_BYPASS_EN
            bp = (cnt == 0) && p && q;
`else
            bp = 1'b0;
`endif
            if (bp) begin
                #1;
                chk("d1_byp", o_do, 32'(d));
            end else begin
                pre = cnt;
                if (q) begin
                    if (pre == 0) munf = 1'b1;
                    else          cnt = 0;
                end
                if (p) begin
                    if (pre == 1) movf = 1'b1;
                    else begin
                        cnt  = 1;
                        mdat = d;
                    end
                end
            end
            tick;
            chk("d1_us", o_us, 32'(cnt));
            chk("d1_ovf", o_ov, 32'(movf));
            chk("d1_unf", o_un, 32'(munf));
            if (cnt == 1) chk("d1_do", o_do, 32'(mdat));
        end
        drv(0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
